// File: rtl/pdm_sequencer.sv
// PDM buffer index sequencer: steps sample_select every `period` clocks, wraps at last_index.
// Optional macro PDM_SEQ_TRIGGER_EN adds an ARMED state that waits for the trigger input.
module pdm_sequencer #(
    parameter int PDM_BUFFER_ADRESS_WIDTH = 7,
    parameter int PERIOD_WIDTH            = 32
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic                               enable,
    input  logic                               trigger,
    input  logic [PERIOD_WIDTH-1:0]            period,
    input  logic [PDM_BUFFER_ADRESS_WIDTH-1:0] last_index,
    output logic [PDM_BUFFER_ADRESS_WIDTH-1:0] sample_select,
    output logic                               data_strobe,
    output logic                               wrap,
    output logic                               busy,
    output logic [PERIOD_WIDTH-1:0]            cycle_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } state_t;

    state_t                             state, state_nxt;
    logic                               run_start;
    logic                               active;
    logic                               advance;
    logic                               wrap_now;
    logic                               ld_pend;
    logic [PERIOD_WIDTH-1:0]            step_cnt;
    logic [PERIOD_WIDTH-1:0]            last_step;
    logic [PERIOD_WIDTH-1:0]            shadow_period;
    logic [PDM_BUFFER_ADRESS_WIDTH-1:0] shadow_last;

`ifndef PDM_SEQ_TRIGGER_EN
    logic unused_trigger;
    assign unused_trigger = trigger;
`endif

    assign active    = (state == RUN) || (state == STOPPING);
    // Period 0 and 1 both mean "advance every clock".
    assign last_step = (shadow_period <= PERIOD_WIDTH'(1)) ? '0 : shadow_period - PERIOD_WIDTH'(1);
    assign advance   = active && (step_cnt == last_step);
    assign wrap_now  = advance && (sample_select == shadow_last);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
`ifdef PDM_SEQ_TRIGGER_EN
                    state_nxt = ARMED;
`else
                    state_nxt = RUN;
                    run_start = 1'b1;
`endif
                end
            end
`ifdef PDM_SEQ_TRIGGER_EN
            ARMED: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (trigger) begin
                    state_nxt = RUN;
                    run_start = 1'b1;
                end
            end
`endif
            // A wrap coinciding with enable falling still lands in STOPPING,
            // so one further full sequence is played out.
            RUN: begin
                if (!enable) state_nxt = STOPPING;
            end
            STOPPING: begin
                if (enable)        state_nxt = RUN;
                else if (wrap_now) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sample_select <= '0;
            data_strobe   <= 1'b0;
            wrap          <= 1'b0;
            cycle_count   <= '0;
            step_cnt      <= '0;
            shadow_period <= '0;
            shadow_last   <= '0;
            ld_pend       <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            ld_pend <= 1'b0;
            // Mux output is valid one clock after a load; nothing is strobed once idle.
            data_strobe <= ld_pend && (state != IDLE);
            if (run_start) begin
                sample_select <= '0;
                step_cnt      <= '0;
                cycle_count   <= '0;
                shadow_period <= period;
                shadow_last   <= last_index;
                ld_pend       <= 1'b1;
            end else if (active) begin
                if (advance) begin
                    step_cnt <= '0;
                    ld_pend  <= 1'b1;
                    if (wrap_now) begin
                        sample_select <= '0;
                        wrap          <= 1'b1;
                        cycle_count   <= cycle_count + PERIOD_WIDTH'(1);
                        shadow_period <= period;
                        shadow_last   <= last_index;
                    end else begin
                        sample_select <= sample_select + PDM_BUFFER_ADRESS_WIDTH'(1);
                    end
                end else begin
                    step_cnt <= step_cnt + PERIOD_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/pdm_sequencer.md
PDM_SEQUENCER -- requirements
Module: pdm_sequencer

Interface
REQ-001 SHALL have parameter PDM_BUFFER_ADRESS_WIDTH, default 7: width of sample_select; buffer depth 2^N.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 32: width of period and cycle_count.
REQ-003 SHALL have port clk, input, 1 bit: the only clock.
REQ-004 SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: level request to run the sequence.
REQ-006 SHALL have port trigger, input, 1 bit: external start trigger, synchronous to clk.
REQ-007 SHALL have port period, input, PERIOD_WIDTH bits: clk cycles per sample step.
REQ-008 SHALL have port last_index, input, PDM_BUFFER_ADRESS_WIDTH bits: final buffer index before wrap.
REQ-009 SHALL have port sample_select, output, PDM_BUFFER_ADRESS_WIDTH bits: index driven to the PDM multiplexer.
REQ-010 SHALL have port data_strobe, output, 1 bit: 1-cycle pulse marking new mux output valid.
REQ-011 SHALL have port wrap, output, 1 bit: 1-cycle pulse on each last_index->0 transition.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port cycle_count, output, PERIOD_WIDTH bits: completed full sequences since run start.

Function
REQ-014 SHALL implement states IDLE, ARMED, RUN, STOPPING, with a registered encoding.
REQ-015 SHALL leave IDLE only on enable=1: to ARMED when PDM_SEQ_TRIGGER_EN is defined, otherwise directly to RUN.
REQ-016 SHALL move ARMED->RUN on the first clk where trigger=1 and enable=1.
REQ-017 SHALL move ARMED->IDLE if enable=0 first.
REQ-018 SHALL, on entry to RUN: set sample_select=0, step counter=0, cycle_count=0, and latch period and last_index into shadow registers.
REQ-019 SHALL, in RUN/STOPPING, increment the step counter each clk.
REQ-020 SHALL, when step counter == shadow_period-1: reset the counter to 0 and advance sample_select by 1.
REQ-021 SHALL treat shadow_period values 0 and 1 both as 1, advancing every clk.
REQ-022 SHALL, on an advance with sample_select == shadow_last_index: set sample_select=0, pulse wrap, increment cycle_count (modulo 2^PERIOD_WIDTH), and re-latch period and last_index.
REQ-023 SHALL apply period/last_index changes only at run entry or at a wrap; never mid-sequence.
REQ-024 SHALL pulse data_strobe exactly 1 clk after every sample_select load, including the load at RUN entry, matching the multiplexer's 1-cycle registered latency.
REQ-025 SHALL move RUN->STOPPING when enable=0.
REQ-026 SHALL, in STOPPING, keep sequencing until the wrap to 0, then go IDLE in the same cycle, still emitting that wrap pulse.
REQ-027 SHALL return STOPPING->RUN if enable reasserts before that wrap; sequence and cycle_count continue undisturbed.
REQ-028 SHALL, in IDLE, hold sample_select at its last value and keep data_strobe=0.
REQ-029 SHALL, on simultaneous wrap and enable fall, handle the wrap first and then enter STOPPING, completing one further full sequence.
REQ-030 SHALL, if shadow_last_index=0, wrap on every advance.

Reset
REQ-031 SHALL, on areset=1, go immediately to IDLE with sample_select=0, data_strobe=0, wrap=0, busy=0, cycle_count=0, step counter=0, and shadow registers=0.
REQ-032 SHALL, on reset asserted mid-run, abort with no further strobes; outputs SHALL be at reset values while areset=1.
REQ-033 SHALL have first transitions occur on the first clk edge after areset deasserts.

Configuration
REQ-034 SHALL use macro PDM_SEQ_TRIGGER_EN: defined -> ARMED state used, run starts on trigger.
REQ-035 SHALL, with PDM_SEQ_TRIGGER_EN undefined, omit ARMED, ignore the trigger port (port kept), and start RUN on the clk after enable rises.

Verification
REQ-036 SHALL cover: macro off, period=4, last_index=3, enable held -> sample_select 0,1,2,3,0 changing every 4 clk; wrap pulse at each 3->0; cycle_count=1 after first wrap.
REQ-037 SHALL cover: period=0, last_index=2 -> sample_select steps every clk 0,1,2,0; data_strobe high every clk from 1 clk after RUN entry.
REQ-038 SHALL cover: enable dropped at sample_select=1 (last_index=3, period=2) -> continues 2,3,0 then IDLE, busy=0, sample_select held 0.
REQ-039 SHALL cover: period changed 4->2 mid-sequence -> old period used until wrap, new period from index 0.
REQ-040 SHALL cover: macro on, enable=1, trigger pulsed 10 clk later -> busy=1 in ARMED, sample_select stays 0, first data_strobe 2 clk after trigger.
REQ-041 SHALL cover: areset pulsed in RUN at sample_select=5 -> sample_select=0, busy=0, no data_strobe until enable re-sequenced.
